pkt_proc_sf_fifo: RTL and testbench

Parametrised store-and-forward packet FIFO, the next generation of the packet-processor memory FSM. It accepts sop/eop-framed packets with a declared length and writes them into an internal 2^ADDR_W-entry buffer. It commits a packet only when its beat count matches the declared length; otherwise it rolls the write pointer back, so the dequeue side never sees partial packets. It sits between the ingress framer and the egress scheduler.

---
 rtl/pkt_proc_sf_fifo_if.sv | 46 ++++
 rtl/pkt_proc_sf_fifo.sv | 195 +++++++++++++++++++
 tb/tb_pkt_proc_sf_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pkt_proc_sf_fifo_if.sv
// rtl/pkt_proc_sf_fifo_if.sv - enqueue/dequeue/status bundle of the store-and-forward packet FIFO
interface pkt_proc_sf_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 12
);
  logic              enq_req;
  logic              in_sop;
  logic              in_eop;
  logic [DATA_W-1:0] wr_data_i;
  logic              pck_len_valid;
  logic [LEN_W-1:0]  pck_len_i;
  logic              deq_req;
  logic [ADDR_W:0]   pck_proc_almost_full_value;
  logic [ADDR_W:0]   pck_proc_almost_empty_value;
  logic [DATA_W-1:0] rd_data_o;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              pck_proc_full;
  logic              pck_proc_empty;
  logic              pck_proc_almost_full;
  logic              pck_proc_almost_empty;
  logic              pck_proc_overflow;
  logic              pck_proc_underflow;
  logic              packet_drop;
  logic [ADDR_W:0]   pck_proc_wr_lvl;
  logic [ADDR_W:0]   pck_proc_pkt_cnt;
  logic [15:0]       pck_proc_drop_cnt;

  modport master (
    output enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i, deq_req,
           pck_proc_almost_full_value, pck_proc_almost_empty_value,
    input  rd_data_o, out_valid, out_sop, out_eop, pck_proc_full, pck_proc_empty,
           pck_proc_almost_full, pck_proc_almost_empty, pck_proc_overflow,
           pck_proc_underflow, packet_drop, pck_proc_wr_lvl, pck_proc_pkt_cnt, pck_proc_drop_cnt
  );

  modport slave (
    input  enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i, deq_req,
           pck_proc_almost_full_value, pck_proc_almost_empty_value,
    output rd_data_o, out_valid, out_sop, out_eop, pck_proc_full, pck_proc_empty,
           pck_proc_almost_full, pck_proc_almost_empty, pck_proc_overflow,
           pck_proc_underflow, packet_drop, pck_proc_wr_lvl, pck_proc_pkt_cnt, pck_proc_drop_cnt
  );
endinterface

// File: rtl/pkt_proc_sf_fifo.sv
// rtl/pkt_proc_sf_fifo.sv - store-and-forward packet FIFO; packets become readable only once
// their beat count matches the declared length, otherwise the write pointer rolls back.
module pkt_proc_sf_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 12
) (
  input  logic pck_proc_int_mem_fsm_clk,
  input  logic pck_proc_int_mem_fsm_rstn,
  input  logic pck_proc_int_mem_fsm_sw_rstn,
  pkt_proc_sf_fifo_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} wr_state_t;

  typedef struct packed {
    wr_state_t         state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     cm_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [PW-1:0]     pkt_cnt;
    logic [PW-1:0]     wr_lvl;
    logic              first;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              packet_drop;
    logic [15:0]       drop_cnt;
    logic [DATA_W-1:0] rd_data;
  } regs_t;

  function automatic regs_t reset_regs();
    regs_t v;
    v = '0;
    v.state = S_IDLE;
    v.first = 1'b1;
    v.empty = 1'b1;
    v.almost_empty = 1'b1;
    return v;
  endfunction

  localparam regs_t RST = reset_regs();

  regs_t r, n;
  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] rd_word;
  logic [PW-1:0] base_ptr, free_sp;
  logic [LEN_W-1:0] beat_inc;
  logic [ADDR_W-1:0] mem_waddr;
  logic eval_sop, mem_we, commit, drop, ovf, rd_ok, eop_rd, len_bad;

  always_ff @(posedge pck_proc_int_mem_fsm_clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) r <= RST;
    else if (!pck_proc_int_mem_fsm_sw_rstn) r <= RST;
    else r <= n;
  end

  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (mem_we && pck_proc_int_mem_fsm_sw_rstn) mem[mem_waddr] <= {bus.in_eop, bus.wr_data_i};
  end

  always_comb begin
    n = r;
    eval_sop = 1'b0;
    base_ptr = r.wr_ptr;
    mem_we = 1'b0;
    mem_waddr = r.wr_ptr[ADDR_W-1:0];
    commit = 1'b0;
    drop = 1'b0;
    ovf = 1'b0;
    free_sp = '0;
    len_bad = 1'b0;
    beat_inc = r.beat_cnt + LEN_ONE;

    if (bus.enq_req) begin
      if (r.state == S_WRITE) begin
        if (bus.in_sop) begin
          // abandon the open packet, then judge the new sop against the rolled-back level
          base_ptr = r.cm_ptr;
          n.wr_ptr = r.cm_ptr;
          drop = 1'b1;
          eval_sop = 1'b1;
        end else if (bus.in_eop) begin
          n.state = S_IDLE;
          if (beat_inc == r.len_q) begin
            mem_we = 1'b1;
            n.wr_ptr = r.wr_ptr + PTR_ONE;
            n.cm_ptr = r.wr_ptr + PTR_ONE;
            commit = 1'b1;
          end else begin
            n.wr_ptr = r.cm_ptr;
            drop = 1'b1;
          end
        end else if (beat_inc > r.len_q) begin
          n.wr_ptr = r.cm_ptr;
          drop = 1'b1;
          n.state = S_DROP;
        end else begin
          mem_we = 1'b1;
          n.wr_ptr = r.wr_ptr + PTR_ONE;
          n.beat_cnt = beat_inc;
        end
      end else if (bus.in_sop) begin
        eval_sop = 1'b1;
      end else if (r.state == S_DROP && bus.in_eop) begin
        n.state = S_IDLE;
      end
    end

    if (eval_sop) begin
      free_sp = PTR_DEPTH - (base_ptr - r.rd_ptr);
      mem_waddr = base_ptr[ADDR_W-1:0];
      len_bad = !bus.pck_len_valid || (bus.pck_len_i == '0);
      if (len_bad || (bus.pck_len_i > LEN_W'(free_sp))) begin
        drop = 1'b1;
        ovf = !len_bad;
        n.wr_ptr = base_ptr;
        n.state = bus.in_eop ? S_IDLE : S_DROP;
      end else begin
        mem_we = 1'b1;
        n.len_q = bus.pck_len_i;
        n.beat_cnt = LEN_ONE;
        if (!bus.in_eop) begin
          n.wr_ptr = base_ptr + PTR_ONE;
          n.state = S_WRITE;
        end else if (bus.pck_len_i == LEN_ONE) begin
          n.wr_ptr = base_ptr + PTR_ONE;
          n.cm_ptr = base_ptr + PTR_ONE;
          commit = 1'b1;
          n.state = S_IDLE;
        end else begin
          n.wr_ptr = base_ptr;
          drop = 1'b1;
          n.state = S_IDLE;
        end
      end
    end

    // reads only ever touch committed entries, so pkt_cnt gates acceptance
    rd_word = mem[r.rd_ptr[ADDR_W-1:0]];
    rd_ok = bus.deq_req && (r.pkt_cnt != '0);
    eop_rd = rd_ok && rd_word[DATA_W];
    n.underflow = bus.deq_req && (r.pkt_cnt == '0);
    n.out_valid = rd_ok;
    n.out_sop = rd_ok && r.first;
    n.out_eop = eop_rd;
    if (rd_ok) begin
      n.rd_data = rd_word[DATA_W-1:0];
      n.rd_ptr = r.rd_ptr + PTR_ONE;
      n.first = rd_word[DATA_W];
    end
    case ({commit, eop_rd})
      2'b10: n.pkt_cnt = r.pkt_cnt + PTR_ONE;
      2'b01: n.pkt_cnt = r.pkt_cnt - PTR_ONE;
      default: n.pkt_cnt = r.pkt_cnt;
    endcase

    n.wr_lvl = n.wr_ptr - n.rd_ptr;
    n.full = (n.wr_lvl == PTR_DEPTH);
    n.empty = (n.pkt_cnt == '0);
    n.almost_full = (n.wr_lvl >= bus.pck_proc_almost_full_value);
    n.almost_empty = ((n.cm_ptr - n.rd_ptr) <= bus.pck_proc_almost_empty_value);
    n.overflow = ovf;
    n.packet_drop = drop;
    if (drop && (r.drop_cnt != 16'hFFFF)) n.drop_cnt = r.drop_cnt + 16'd1;
  end

  assign bus.rd_data_o = r.rd_data;
  assign bus.out_valid = r.out_valid;
  assign bus.out_sop = r.out_sop;
  assign bus.out_eop = r.out_eop;
  assign bus.pck_proc_full = r.full;
  assign bus.pck_proc_empty = r.empty;
  assign bus.pck_proc_almost_full = r.almost_full;
  assign bus.pck_proc_almost_empty = r.almost_empty;
  assign bus.pck_proc_overflow = r.overflow;
  assign bus.pck_proc_underflow = r.underflow;
  assign bus.packet_drop = r.packet_drop;
  assign bus.pck_proc_wr_lvl = r.wr_lvl;
  assign bus.pck_proc_pkt_cnt = r.pkt_cnt;
  assign bus.pck_proc_drop_cnt = r.drop_cnt;
endmodule

// File: tb/tb_pkt_proc_sf_fifo.sv
// tb/tb_pkt_proc_sf_fifo.sv - directed bench for pkt_proc_sf_fifo with hand-computed expectations
module tb_pkt_proc_sf_fifo;
  logic clk;
  logic rstn;
  logic sw_rstn;
  int vectors;
  int miscompares;

  pkt_proc_sf_fifo_if #(.DATA_W(32), .ADDR_W(4), .LEN_W(12)) bus ();

  pkt_proc_sf_fifo #(.DATA_W(32), .ADDR_W(4), .LEN_W(12)) dut (
    .pck_proc_int_mem_fsm_clk(clk),
    .pck_proc_int_mem_fsm_rstn(rstn),
    .pck_proc_int_mem_fsm_sw_rstn(sw_rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic enq, input logic sop, input logic eop, input logic lv,
                       input logic [11:0] len, input logic [31:0] d, input logic deq);
    bus.enq_req = enq;
    bus.in_sop = sop;
    bus.in_eop = eop;
    bus.pck_len_valid = lv;
    bus.pck_len_i = len;
    bus.wr_data_i = d;
    bus.deq_req = deq;
    @(posedge clk);
    #1;
    bus.enq_req = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.pck_len_valid = 1'b0;
    bus.deq_req = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    sw_rstn = 1'b1;
    bus.enq_req = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.wr_data_i = '0;
    bus.pck_len_valid = 1'b0;
    bus.pck_len_i = '0;
    bus.deq_req = 1'b0;
    bus.pck_proc_almost_full_value = 5'd14;
    bus.pck_proc_almost_empty_value = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", bus.pck_proc_empty, 1);
    chk("rst_almost_empty", bus.pck_proc_almost_empty, 1);
    chk("rst_full", bus.pck_proc_full, 0);
    chk("rst_almost_full", bus.pck_proc_almost_full, 0);
    chk("rst_wr_lvl", bus.pck_proc_wr_lvl, 0);
    chk("rst_pkt_cnt", bus.pck_proc_pkt_cnt, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_drop_cnt", bus.pck_proc_drop_cnt, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // len=4 packet, then read it back
    drive(1, 1, 0, 1, 12'd4, 32'hA0, 0);
    chk("p1_lvl_b1", bus.pck_proc_wr_lvl, 1);
    chk("p1_empty_b1", bus.pck_proc_empty, 1);
    chk("p1_aempty_b1", bus.pck_proc_almost_empty, 1);
    drive(1, 0, 0, 0, 12'd0, 32'hA1, 0);
    drive(1, 0, 0, 0, 12'd0, 32'hA2, 0);
    drive(1, 0, 1, 0, 12'd0, 32'hA3, 0);
    chk("p1_pkt_cnt", bus.pck_proc_pkt_cnt, 1);
    chk("p1_lvl", bus.pck_proc_wr_lvl, 4);
    chk("p1_empty", bus.pck_proc_empty, 0);
    chk("p1_aempty", bus.pck_proc_almost_empty, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 12'd0, 32'h0, 1);
      chk("p1_rd_valid", bus.out_valid, 1);
      chk("p1_rd_data", bus.rd_data_o, 32'hA0 + 32'(i));
      chk("p1_rd_sop", bus.out_sop, i == 0);
      chk("p1_rd_eop", bus.out_eop, i == 3);
    end
    chk("p1_pkt_cnt_end", bus.pck_proc_pkt_cnt, 0);
    chk("p1_empty_end", bus.pck_proc_empty, 1);
    chk("p1_lvl_end", bus.pck_proc_wr_lvl, 0);
    drive(0, 0, 0, 0, 12'd0, 32'h0, 0);
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_hold", bus.rd_data_o, 32'hA3);

    // declared len=5, eop on beat 3
    drive(1, 1, 0, 1, 12'd5, 32'hB0, 0);
    drive(1, 0, 0, 0, 12'd0, 32'hB1, 0);
    drive(1, 0, 1, 0, 12'd0, 32'hB2, 0);
    chk("short_drop", bus.packet_drop, 1);
    chk("short_lvl", bus.pck_proc_wr_lvl, 0);
    chk("short_pkt_cnt", bus.pck_proc_pkt_cnt, 0);
    chk("short_drop_cnt", bus.pck_proc_drop_cnt, 1);
    drive(0, 0, 0, 0, 12'd0, 32'h0, 0);
    chk("short_drop_pulse", bus.packet_drop, 0);

    // underflow on an empty FIFO
    drive(0, 0, 0, 0, 12'd0, 32'h0, 1);
    chk("udf_pulse", bus.pck_proc_underflow, 1);
    chk("udf_valid", bus.out_valid, 0);
    drive(0, 0, 0, 0, 12'd0, 32'h0, 0);
    chk("udf_pulse_end", bus.pck_proc_underflow, 0);

    // len=14 packet, with a read attempted during its first (uncommitted) beat
    for (int i = 0; i < 14; i++) begin
      drive(1, i == 0, i == 13, i == 0, 12'd14, 32'hC0 + 32'(i), i == 0);
      if (i == 0) begin
        chk("mid_udf", bus.pck_proc_underflow, 1);
        chk("mid_valid", bus.out_valid, 0);
      end
    end
    chk("p14_pkt_cnt", bus.pck_proc_pkt_cnt, 1);
    chk("p14_lvl", bus.pck_proc_wr_lvl, 14);
    chk("p14_afull", bus.pck_proc_almost_full, 1);
    chk("p14_full", bus.pck_proc_full, 0);
    drive(1, 1, 0, 1, 12'd4, 32'hBAD0, 0);
    chk("ovf_pulse", bus.pck_proc_overflow, 1);
    chk("ovf_drop", bus.packet_drop, 1);
    chk("ovf_drop_cnt", bus.pck_proc_drop_cnt, 2);
    chk("ovf_lvl", bus.pck_proc_wr_lvl, 14);
    drive(1, 0, 0, 0, 12'd0, 32'hBAD1, 0);
    drive(1, 0, 0, 0, 12'd0, 32'hBAD2, 0);
    drive(1, 0, 1, 0, 12'd0, 32'hBAD3, 0);
    chk("ovf_discard_lvl", bus.pck_proc_wr_lvl, 14);
    chk("ovf_pulse_end", bus.pck_proc_overflow, 0);
    chk("ovf_no_drop", bus.packet_drop, 0);
    drive(1, 1, 0, 1, 12'd2, 32'h60, 0);
    drive(1, 0, 1, 0, 12'd0, 32'h61, 0);
    chk("fill_pkt_cnt", bus.pck_proc_pkt_cnt, 2);
    chk("fill_lvl", bus.pck_proc_wr_lvl, 16);
    chk("fill_full", bus.pck_proc_full, 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 12'd0, 32'h0, 1);
      chk("drain_data", bus.rd_data_o, (i < 14) ? 32'hC0 + 32'(i) : 32'h60 + 32'(i - 14));
      chk("drain_sop", bus.out_sop, (i == 0) || (i == 14));
      chk("drain_eop", bus.out_eop, (i == 13) || (i == 15));
      if (i == 0) chk("drain_full_off", bus.pck_proc_full, 0);
    end
    chk("drain_empty", bus.pck_proc_empty, 1);
    chk("drain_lvl", bus.pck_proc_wr_lvl, 0);

    // back-to-back 1-beat packets read as they commit, wrapping the pointers
    drive(1, 1, 1, 1, 12'd1, 32'hD00, 0);
    chk("one_pkt_cnt", bus.pck_proc_pkt_cnt, 1);
    chk("one_empty", bus.pck_proc_empty, 0);
    for (int k = 1; k < 48; k++) begin
      drive(1, 1, 1, 1, 12'd1, 32'hD00 + 32'(k), 1);
      chk("one_data", bus.rd_data_o, 32'hD00 + 32'(k - 1));
      chk("one_flags", {29'd0, bus.out_valid, bus.out_sop, bus.out_eop}, 32'h7);
      chk("one_pkt_cnt_hold", bus.pck_proc_pkt_cnt, 1);
    end
    drive(0, 0, 0, 0, 12'd0, 32'h0, 1);
    chk("one_last", bus.rd_data_o, 32'hD2F);
    chk("one_empty_end", bus.pck_proc_empty, 1);
    chk("one_lvl_end", bus.pck_proc_wr_lvl, 0);

    // soft reset in the middle of a packet
    drive(1, 1, 0, 1, 12'd3, 32'hE0, 0);
    drive(1, 0, 0, 0, 12'd0, 32'hE1, 0);
    sw_rstn = 1'b0;
    drive(0, 0, 0, 0, 12'd0, 32'h0, 0);
    sw_rstn = 1'b1;
    chk("swr_lvl", bus.pck_proc_wr_lvl, 0);
    chk("swr_pkt_cnt", bus.pck_proc_pkt_cnt, 0);
    chk("swr_empty", bus.pck_proc_empty, 1);
    chk("swr_aempty", bus.pck_proc_almost_empty, 1);
    chk("swr_drop", bus.packet_drop, 0);
    chk("swr_drop_cnt", bus.pck_proc_drop_cnt, 0);
    drive(1, 1, 0, 1, 12'd2, 32'hF0, 0);
    drive(1, 0, 1, 0, 12'd0, 32'hF1, 0);
    chk("swr_next_pkt", bus.pck_proc_pkt_cnt, 1);
    chk("swr_next_lvl", bus.pck_proc_wr_lvl, 2);
    drive(0, 0, 0, 0, 12'd0, 32'h0, 1);
    chk("swr_rd0", bus.rd_data_o, 32'hF0);
    chk("swr_rd0_sop", bus.out_sop, 1);
    drive(0, 0, 0, 0, 12'd0, 32'h0, 1);
    chk("swr_rd1", bus.rd_data_o, 32'hF1);
    chk("swr_rd1_eop", bus.out_eop, 1);
    chk("swr_pkt_cnt_end", bus.pck_proc_pkt_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
